// File: rtl/sad_result_arbiter_pkg.sv
// Shared motion-estimation definitions: SAD width, core identifiers and the
// round-robin pick used when both cores have results waiting.
package sad_result_arbiter_pkg;

    localparam int SAD_W = 22;

    typedef enum logic {
        CORE0 = 1'b0,
        CORE1 = 1'b1
    } core_id_e;

    // Alternate on contention; otherwise serve whichever core has data.
    function automatic core_id_e rr_pick(input logic has0, input logic has1, input core_id_e last);
        core_id_e pick;
        if (has0 && has1) begin
            pick = (last == CORE0) ? CORE1 : CORE0;
        end else if (has0) begin
            pick = CORE0;
        end else begin
            pick = CORE1;
        end
        return pick;
    endfunction

endpackage

// File: rtl/sad_result_arbiter_fifo.sv
// Small synchronous FIFO buffering one core's {sad, idx} results.
// A push into a full FIFO succeeds only when the head is popped on the same edge.
module sad_fifo
    import sad_result_arbiter_pkg::*;
#(
    parameter int WIDTH = SAD_W + 12,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    // Qualify push/pop against occupancy.
    always_comb begin
        w_full    = (r_count == CNT_W'(DEPTH));
        w_do_pop  = i_pop && (r_count != {CNT_W{1'b0}});
        w_do_push = i_push && (!w_full || w_do_pop);
    end

    // Pointer and occupancy state; pointers wrap naturally at DEPTH.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == {CNT_W{1'b0}});

endmodule

// File: rtl/sad_result_arbiter.sv
// Merges the two motion-estimation cores' min-SAD results into one ordered
// valid/ready stream with per-core block indices, overflow flags and frame-done.
module sad_result_arbiter
    import sad_result_arbiter_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int IDX_W        = 12,
    parameter int FRAME_BLOCKS = 396
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SAD_W-1:0] min_sad0,
    input  logic             finish_a_cur0,
    input  logic [SAD_W-1:0] min_sad1,
    input  logic             finish_a_cur1,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [SAD_W-1:0] out_sad,
    output logic             out_src,
    output logic [IDX_W-1:0] out_idx,
    output logic             frame_done,
    output logic             ovf0,
    output logic             ovf1
);

    localparam int ENT_W = SAD_W + IDX_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int FC_W  = $clog2(FRAME_BLOCKS + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_BLOCKS - 1);

    logic [ENT_W-1:0] w_head0, w_head1, w_head;
    logic [CNT_W-1:0] w_cnt0, w_cnt1;
    logic             w_empty0, w_empty1;
    logic             w_load, w_any, w_xfer;
    logic             w_pop0, w_pop1, w_acc0, w_acc1;
    core_id_e         w_grant;

    logic             r_out_valid;
    logic [SAD_W-1:0] r_out_sad;
    logic             r_out_src;
    logic [IDX_W-1:0] r_out_idx;
    logic             r_frame_done;
    logic             r_ovf0, r_ovf1;
    logic [IDX_W-1:0] r_idx0, r_idx1;
    logic [FC_W-1:0]  r_frame_cnt;
    core_id_e         r_last_grant;

    sad_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_fifo0 (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_push  (w_acc0),
        .i_data  ({min_sad0, r_idx0}),
        .i_pop   (w_pop0),
        .o_data  (w_head0),
        .o_count (w_cnt0),
        .o_empty (w_empty0)
    );

    sad_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_fifo1 (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_push  (w_acc1),
        .i_data  ({min_sad1, r_idx1}),
        .i_pop   (w_pop1),
        .o_data  (w_head1),
        .o_count (w_cnt1),
        .o_empty (w_empty1)
    );

    // Arbitration, pop selection and push acceptance.
    always_comb begin
        w_load  = !r_out_valid || out_ready;
        w_xfer  = r_out_valid && out_ready;
        w_any   = !w_empty0 || !w_empty1;
        w_grant = rr_pick(!w_empty0, !w_empty1, r_last_grant);
        w_pop0  = w_load && w_any && (w_grant == CORE0);
        w_pop1  = w_load && w_any && (w_grant == CORE1);
        w_head  = (w_grant == CORE0) ? w_head0 : w_head1;
        w_acc0  = finish_a_cur0 && ((w_cnt0 < CNT_W'(DEPTH)) || w_pop0);
        w_acc1  = finish_a_cur1 && ((w_cnt1 < CNT_W'(DEPTH)) || w_pop1);
    end

    // Output register: holds steady under back-pressure, reloads from the granted head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid  <= 1'b0;
            r_out_sad    <= {SAD_W{1'b0}};
            r_out_src    <= 1'b0;
            r_out_idx    <= {IDX_W{1'b0}};
            r_last_grant <= CORE1;
        end else if (w_load) begin
            if (w_any) begin
                r_out_valid  <= 1'b1;
                r_out_sad    <= w_head[ENT_W-1:IDX_W];
                r_out_idx    <= w_head[IDX_W-1:0];
                r_out_src    <= w_grant;
                r_last_grant <= w_grant;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Per-core block indices advance only on accepted results; drops are sticky.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx0 <= {IDX_W{1'b0}};
            r_idx1 <= {IDX_W{1'b0}};
            r_ovf0 <= 1'b0;
            r_ovf1 <= 1'b0;
        end else begin
            if (w_acc0) begin
                r_idx0 <= r_idx0 + IDX_W'(1);
            end else if (finish_a_cur0) begin
                r_ovf0 <= 1'b1;
            end
            if (w_acc1) begin
                r_idx1 <= r_idx1 + IDX_W'(1);
            end else if (finish_a_cur1) begin
                r_ovf1 <= 1'b1;
            end
        end
    end

    // Frame transfer counter with a one-cycle done pulse on wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_cnt  <= {FC_W{1'b0}};
            r_frame_done <= 1'b0;
        end else if (w_xfer) begin
            if (r_frame_cnt == FC_LAST) begin
                r_frame_cnt  <= {FC_W{1'b0}};
                r_frame_done <= 1'b1;
            end else begin
                r_frame_cnt  <= r_frame_cnt + FC_W'(1);
                r_frame_done <= 1'b0;
            end
        end else begin
            r_frame_done <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_sad    = r_out_sad;
    assign out_src    = r_out_src;
    assign out_idx    = r_out_idx;
    assign frame_done = r_frame_done;
    assign ovf0       = r_ovf0;
    assign ovf1       = r_ovf1;

endmodule

// File: tb/tb_sad_result_arbiter.sv
// Randomised and directed scoreboard bench for sad_result_arbiter against a
// queue-based reference model of the merge/arbitration rules.
module tb_sad_result_arbiter;

    localparam int DEPTH = 4;
    localparam int IDX_W = 12;
    localparam int FB    = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [21:0]       min_sad0 = 22'd0, min_sad1 = 22'd0;
    logic              finish_a_cur0 = 1'b0, finish_a_cur1 = 1'b0;
    logic              out_ready = 1'b0;
    logic              out_valid, out_src, frame_done, ovf0, ovf1;
    logic [21:0]       out_sad;
    logic [IDX_W-1:0]  out_idx;

    sad_result_arbiter #(.DEPTH(DEPTH), .IDX_W(IDX_W), .FRAME_BLOCKS(FB)) dut (
        .clk           (clk),
        .rst           (rst),
        .min_sad0      (min_sad0),
        .finish_a_cur0 (finish_a_cur0),
        .min_sad1      (min_sad1),
        .finish_a_cur1 (finish_a_cur1),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_sad       (out_sad),
        .out_src       (out_src),
        .out_idx       (out_idx),
        .frame_done    (frame_done),
        .ovf0          (ovf0),
        .ovf1          (ovf1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [21:0]      sad;
        logic             src;
        logic [IDX_W-1:0] idx;
    } ent_t;

    ent_t q0[$], q1[$], exp_q[$];
    logic [IDX_W-1:0] m_idx0, m_idx1;
    bit   m_ov, m_last, m_fd, m_ovf0, m_ovf1;
    int   m_fcnt;
    int   checks = 0, errors = 0, fd_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-core queues, round-robin on contention, one output slot.
    always @(posedge clk or negedge rst) begin : model
        bit load, xfer, g, pop0, pop1;
        int s0, s1;
        ent_t e;
        if (!rst) begin
            q0.delete(); q1.delete(); exp_q.delete();
            m_idx0 = '0; m_idx1 = '0;
            m_ov = 1'b0; m_last = 1'b1; m_fd = 1'b0;
            m_ovf0 = 1'b0; m_ovf1 = 1'b0; m_fcnt = 0;
        end else begin
            load = !m_ov || out_ready;
            xfer = m_ov && out_ready;
            m_fd = 1'b0;
            if (xfer) begin
                m_fcnt++;
                if (m_fcnt == FB) begin
                    m_fcnt = 0;
                    m_fd   = 1'b1;
                end
            end
            s0 = q0.size(); s1 = q1.size();
            pop0 = 1'b0; pop1 = 1'b0;
            if (load) begin
                if (s0 > 0 && s1 > 0) g = !m_last;
                else if (s0 > 0)      g = 1'b0;
                else                  g = 1'b1;
                if (s0 > 0 || s1 > 0) begin
                    if (!g) begin e = q0.pop_front(); pop0 = 1'b1; end
                    else    begin e = q1.pop_front(); pop1 = 1'b1; end
                    exp_q.push_back(e);
                    m_ov = 1'b1;
                    m_last = g;
                end else begin
                    m_ov = 1'b0;
                end
            end
            if (finish_a_cur0) begin
                if (s0 < DEPTH || pop0) begin
                    e.sad = min_sad0; e.src = 1'b0; e.idx = m_idx0;
                    q0.push_back(e);
                    m_idx0 = m_idx0 + 12'd1;
                end else begin
                    m_ovf0 = 1'b1;
                end
            end
            if (finish_a_cur1) begin
                if (s1 < DEPTH || pop1) begin
                    e.sad = min_sad1; e.src = 1'b1; e.idx = m_idx1;
                    q1.push_back(e);
                    m_idx1 = m_idx1 + 12'd1;
                end else begin
                    m_ovf1 = 1'b1;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every transfer and checks stall stability.
    bit               prev_stall = 1'b0;
    logic [21:0]      hold_sad;
    logic             hold_src;
    logic [IDX_W-1:0] hold_idx;
    always @(negedge clk) begin : monitor
        ent_t e;
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            chk("frame_done", 32'(frame_done), 32'(m_fd));
            chk("ovf0", 32'(ovf0), 32'(m_ovf0));
            chk("ovf1", 32'(ovf1), 32'(m_ovf1));
            if (prev_stall && out_valid) begin
                chk("stall_sad", 32'(out_sad), 32'(hold_sad));
                chk("stall_src", 32'(out_src), 32'(hold_src));
                chk("stall_idx", 32'(out_idx), 32'(hold_idx));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("out_sad", 32'(out_sad), 32'(e.sad));
                    chk("out_src", 32'(out_src), 32'(e.src));
                    chk("out_idx", 32'(out_idx), 32'(e.idx));
                end
            end
            prev_stall = out_valid && !out_ready;
            hold_sad = out_sad; hold_src = out_src; hold_idx = out_idx;
        end
    end

    task automatic step(input bit f0, input logic [21:0] s0, input bit f1,
                        input logic [21:0] s1, input bit rdy);
        finish_a_cur0 = f0; min_sad0 = s0;
        finish_a_cur1 = f1; min_sad1 = s1;
        out_ready = rdy;
        @(posedge clk);
        #2;
        if (frame_done) fd_seen++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'(0));
        chk({tag, "_sad"}, 32'(out_sad), 32'(0));
        chk({tag, "_src"}, 32'(out_src), 32'(0));
        chk({tag, "_idx"}, 32'(out_idx), 32'(0));
        chk({tag, "_fd"}, 32'(frame_done), 32'(0));
        chk({tag, "_ovf0"}, 32'(ovf0), 32'(0));
        chk({tag, "_ovf1"}, 32'(ovf1), 32'(0));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk_all_zero("rst");
        step(1'b0, 22'd0, 1'b0, 22'd0, 1'b0);
        step(1'b0, 22'd0, 1'b0, 22'd0, 1'b0);
        rst = 1'b1;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #2;
        chk_all_zero("init");
        rst = 1'b1;

        // Single core-0 result: visible after the following edge, then consumed.
        step(1'b1, 22'd1234, 1'b0, 22'd0, 1'b1);
        step(1'b0, 22'd0, 1'b0, 22'd0, 1'b1);
        chk("lat_valid", 32'(out_valid), 32'(1));
        chk("lat_sad", 32'(out_sad), 32'(1234));
        chk("lat_src", 32'(out_src), 32'(0));
        chk("lat_idx", 32'(out_idx), 32'(0));
        step(1'b0, 22'd0, 1'b0, 22'd0, 1'b1);
        chk("drain_valid", 32'(out_valid), 32'(0));

        // Simultaneous strobes, twice.
        step(1'b1, 22'd10, 1'b1, 22'd20, 1'b1);
        step(1'b1, 22'd10, 1'b1, 22'd20, 1'b1);
        repeat (5) step(1'b0, 22'd0, 1'b0, 22'd0, 1'b1);

        // Back-pressure overflow on core 1.
        for (int k = 1; k <= 6; k++) step(1'b0, 22'd0, 1'b1, 22'(k), 1'b0);
        repeat (3) step(1'b0, 22'd0, 1'b0, 22'd0, 1'b0);
        chk("stall_head", 32'(out_sad), 32'(1));
        chk("ovf1_set", 32'(ovf1), 32'(1));
        repeat (10) step(1'b0, 22'd0, 1'b0, 22'd0, 1'b1);
        chk("ovf1_sticky", 32'(ovf1), 32'(1));

        // Frame boundary: eight alternating results make two pulses.
        do_reset();
        fd_seen = 0;
        for (int i = 0; i < 8; i++)
            step(i % 2 == 0, 22'(100 + i), i % 2 == 1, 22'(200 + i), 1'b1);
        repeat (6) step(1'b0, 22'd0, 1'b0, 22'd0, 1'b1);
        chk("frame_pulses", 32'(fd_seen), 32'(2));

        // Random traffic.
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 9) < 4, 22'($urandom), $urandom_range(0, 9) < 4,
                 22'($urandom), $urandom_range(0, 9) < 7);

        // Reset with work queued.
        step(1'b1, 22'd5, 1'b1, 22'd6, 1'b0);
        step(1'b1, 22'd7, 1'b0, 22'd0, 1'b0);
        step(1'b1, 22'd8, 1'b1, 22'd9, 1'b0);
        do_reset();
        step(1'b1, 22'd777, 1'b0, 22'd0, 1'b1);
        step(1'b0, 22'd0, 1'b0, 22'd0, 1'b0);
        chk("post_rst_valid", 32'(out_valid), 32'(1));
        chk("post_rst_sad", 32'(out_sad), 32'(777));
        chk("post_rst_idx", 32'(out_idx), 32'(0));
        chk("post_rst_ovf0", 32'(ovf0), 32'(0));
        chk("post_rst_ovf1", 32'(ovf1), 32'(0));

        // Bounded drain of everything still expected.
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            step(1'b0, 22'd0, 1'b0, 22'd0, 1'b1);
            n++;
        end
        chk("drain_timeout", 32'(n >= 100), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sad_result_arbiter.md
Name: sad_result_arbiter

Overview:
Merges the minimum-SAD results of the two motion-estimation cores (core 0, core 1) into one ordered output stream for the downstream result writer and MV store. Each core pulses its finish strobe with its 22-bit min SAD; the block buffers each core in a small FIFO and tags entries with a per-core block index. It round-robin arbitrates onto a valid/ready output and counts transfers to flag end-of-frame. Sits between the dual SAD datapath and the single result sink.

Parameters:
DEPTH, 4, entries per core FIFO; power of 2, minimum 2
IDX_W, 12, width of per-core block index counter
FRAME_BLOCKS, 396, output transfers per frame (CIF 16x16 blocks); minimum 1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
min_sad0  in  22  core 0 minimum SAD, valid when finish_a_cur0=1
finish_a_cur0  in  1  core 0 one-cycle result strobe
min_sad1  in  22  core 1 minimum SAD, valid when finish_a_cur1=1
finish_a_cur1  in  1  core 1 one-cycle result strobe
out_ready  in  1  sink accepts output this cycle
out_valid  out  1  output entry valid
out_sad  out  22  SAD of output entry
out_src  out  1  source core (0/1)
out_idx  out  IDX_W  per-core block index of output entry
frame_done  out  1  one-cycle pulse after the FRAME_BLOCKS-th transfer
ovf0  out  1  sticky: core 0 result dropped
ovf1  out  1  sticky: core 1 result dropped

Behaviour:
- One clock (clk); reset rst is asynchronous, active-low. Reset: all outputs 0; FIFOs empty; index counters 0; frame counter 0; last_grant=1 (core 0 wins first tie).
- Push N: finish_a_curN=1 at an edge. Accepted if countN<DEPTH, or countN==DEPTH and FIFO N is popped the same edge. Entry = {min_sadN, idxN}; idxN increments per accepted push and wraps at 2^IDX_W.
- Full and no same-edge pop: drop the result, idxN unchanged, ovfN<=1. ovfN clears only on reset.
- Output register load condition: out_valid==0 or (out_valid && out_ready).
- Arbitration at load: both FIFOs non-empty -> grant = !last_grant; exactly one non-empty -> that one; none -> out_valid<=0 if the current entry was consumed.
- On grant: pop the head; out_sad/out_src/out_idx <= head; out_valid<=1; last_grant<=grant.
- Stall: while out_valid && !out_ready, all output fields stay stable and nothing is popped.
- Latency: strobe sampled at edge E, FIFO and output register empty -> out_valid high after edge E+1. Sustained throughput is 1 transfer/cycle.
- Simultaneous strobes on both cores in one cycle: both pushed; core order is set by round-robin.
- Transfer = out_valid && out_ready at an edge.
  - frame counter +1 per transfer.
  - On the transfer that makes the count FRAME_BLOCKS: counter<=0; frame_done=1 for exactly the following cycle.
  - No transfer: frame_done=0.
- Reset mid-operation: queued and in-flight results are discarded; the stream restarts at idx 0 for both cores.
- FIFO count register width: $clog2(DEPTH)+1; read/write pointers wrap at DEPTH.

Decomposition:
- Shared ME package: SAD_W=22, SAD width constant, and the core-id encoding (CORE0=0, CORE1=1).
- One natural sub-module: sad_fifo (sync FIFO, width SAD_W+IDX_W, depth DEPTH, push/pop/count/full/empty), instantiated once per core.
- Arbiter, output register and frame counter stay in the top.

Test Plan:
- Reset then single finish_a_cur0 with min_sad0=22'd1234 -> out_valid high after edge E+1; out_sad=1234, out_src=0, out_idx=0. out_ready=1 -> out_valid low next cycle.
- Both strobes same cycle (sad0=10, sad1=20), out_ready=1 -> outputs (10,src0,idx0) then (20,src1,idx0); repeat once more -> (src0,idx1) then (src1,idx1) order.
- out_ready=0, six core-1 strobes with sad 1..6, DEPTH=4 -> out_valid stuck on sad 1, FIFO holds 2..5, sad 6 dropped, ovf1=1. Release ready -> 1,2,3,4,5 with idx 0..4; ovf1 stays 1.
- Hold out_ready low 3 cycles while out_valid=1 -> out_sad/out_src/out_idx unchanged every cycle.
- FRAME_BLOCKS=4, eight results alternating cores -> frame_done single-cycle pulse after the 4th and 8th transfers only.
- Assert rst low mid-stream with entries queued -> all outputs 0 immediately. After release, the next core-0 result carries out_idx=0; ovf flags cleared.
